// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: valid/ready word handshake between the receiver and its parallel consumer
interface serial_frame_rx_if #(parameter int DATA_W = 4);
    logic [DATA_W-1:0] m_data;
    logic m_valid;
    logic m_ready;
    modport master (output m_data, m_valid, input m_ready);
    modport slave (input m_data, m_valid, output m_ready);
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: framed serial word receiver with a one-entry valid/ready buffer; SERIAL_FRAME_RX_PARITY_EN adds an even-parity bit
module serial_frame_rx #(
    parameter int DATA_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_en,
    input  logic s_din,
    input  logic dir,
    serial_frame_rx_if.master m,
    output logic busy,
    output logic overrun,
    output logic frame_err,
    output logic parity_err
);
    localparam int CW = $clog2(DATA_W + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t state, state_nx;
    logic dir_q;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] sh;
    logic deliver, ferr;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic par_bad, perr;
`endif
    assign busy = state != IDLE;
    always_comb begin
        state_nx = state;
        deliver = 1'b0;
        ferr = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        perr = 1'b0;
`endif
        if (bit_en) begin
            unique case (state)
                IDLE: state_nx = s_din ? IDLE : DATA;
                DATA: state_nx = (cnt == CW'(DATA_W - 1)) ? AFTER_DATA : DATA;
                PARITY: state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    ferr = !s_din;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    perr = s_din & par_bad;
                    deliver = s_din & !par_bad;
`else
                    deliver = s_din;
`endif
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
            cnt <= '0;
            sh <= '0;
        end else if (bit_en) begin
            if (state == IDLE && !s_din) begin
                dir_q <= dir;
                cnt <= '0;
            end
            if (state == DATA) begin
                sh <= dir_q ? {sh[DATA_W-2:0], s_din} : {s_din, sh[DATA_W-1:1]};
                cnt <= cnt + 1'b1;
            end
        end
    end
`ifdef SERIAL_FRAME_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_bad <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad <= (bit_en && state == PARITY) ? (s_din != ^sh) : par_bad;
            parity_err <= perr;
        end
    end
`else
    assign parity_err = 1'b0;
`endif
    // A pop in the delivery cycle frees the slot, so the new word still lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m.m_data <= '0;
            m.m_valid <= 1'b0;
            overrun <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun <= deliver & m.m_valid & !m.m_ready;
            frame_err <= ferr;
            if (deliver && (!m.m_valid || m.m_ready)) begin
                m.m_data <= sh;
                m.m_valid <= 1'b1;
            end else if (m.m_valid && m.m_ready) begin
                m.m_valid <= 1'b0;
            end
        end
    end
endmodule
